// File: rtl/ifetch_stage.sv
// Instruction fetch: sequential PC generation with credit-limited requests, an ordered
// response FIFO feeding decode, and redirect handling that squashes stale in-flight words.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_v,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_v,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_v,
  input  logic [31:0] redirect_pc,
  input  logic        decode_stall,
  output logic        ifetch_decode_v,
  output logic [31:0] ifetch_decode_pc,
  output logic [31:0] ifetch_decode_instruction
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding, squash_cnt, squash_next, fifo_cnt;
  logic [CW:0]   inflight;
  logic [PW-1:0] tag_wr, tag_rd, fifo_wr, fifo_rd;
  logic [31:0]   tag_mem  [DEPTH];
  logic [31:0]   fifo_pc  [DEPTH];
  logic [31:0]   fifo_ins [DEPTH];
  logic          accept, resp_take, fifo_empty, bypass, push, pop;
  logic [31:0]   resp_pc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Request side: credits count both in-flight and queued words so responses always fit
  assign inflight      = {1'b0, outstanding} + {1'b0, fifo_cnt};
  assign imem_req_v    = (state != S_IDLE) && !redirect_v && (inflight < DEPTH_C);
  assign imem_req_addr = fetch_pc;
  assign accept        = imem_req_v && imem_req_ready;

  // Response side: the tag queue pops on every response, squashed or not, to stay aligned
  assign resp_pc    = tag_mem[tag_rd];
  assign resp_take  = imem_resp_v && (squash_cnt == '0) && !redirect_v;
  assign fifo_empty = (fifo_cnt == '0);
  assign bypass     = resp_take && fifo_empty && !decode_stall;
  assign push       = resp_take && !bypass;
  assign pop        = !redirect_v && !decode_stall && !fifo_empty;

  always_comb begin
    squash_next = squash_cnt;
    if (redirect_v)
      squash_next = outstanding - CW'(imem_resp_v);
    else if (imem_resp_v && (squash_cnt != '0))
      squash_next = squash_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      squash_cnt  <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      if (state == S_IDLE)
        state <= S_FETCH;
      else
        state <= (squash_next != '0) ? S_DRAIN : S_FETCH;
      if (redirect_v)
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (accept)
        fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(accept) - CW'(imem_resp_v);
      squash_cnt  <= squash_next;
      if (accept)
        tag_wr <= ptr_inc(tag_wr);
      if (imem_resp_v)
        tag_rd <= ptr_inc(tag_rd);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_cnt <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
    end else if (redirect_v) begin
      fifo_cnt <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
    end else begin
      if (push)
        fifo_wr <= ptr_inc(fifo_wr);
      if (pop)
        fifo_rd <= ptr_inc(fifo_rd);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      tag_mem[tag_wr] <= fetch_pc;
    if (push) begin
      fifo_pc[fifo_wr]  <= resp_pc;
      fifo_ins[fifo_wr] <= imem_resp_data;
    end
  end

  // Decode-facing registers: bubbles become NOP and the last pc is kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifetch_decode_v           <= 1'b0;
      ifetch_decode_pc          <= 32'h0;
      ifetch_decode_instruction <= NOP;
    end else if (redirect_v) begin
      ifetch_decode_v           <= 1'b0;
      ifetch_decode_instruction <= NOP;
    end else if (!decode_stall) begin
      if (pop) begin
        ifetch_decode_v           <= 1'b1;
        ifetch_decode_pc          <= fifo_pc[fifo_rd];
        ifetch_decode_instruction <= fifo_ins[fifo_rd];
      end else if (bypass) begin
        ifetch_decode_v           <= 1'b1;
        ifetch_decode_pc          <= resp_pc;
        ifetch_decode_instruction <= imem_resp_data;
      end else begin
        ifetch_decode_v           <= 1'b0;
        ifetch_decode_instruction <= NOP;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: in-order memory model with configurable latency and a
// scoreboard of expected decode-side (pc, instruction) pairs.
module tb_ifetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_v, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_v = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_v;
  logic [31:0] redirect_pc;
  logic        decode_stall;
  logic        ifetch_decode_v;
  logic [31:0] ifetch_decode_pc, ifetch_decode_instruction;
  logic        w_req_v, w_v;
  logic [31:0] w_req_addr, w_pc, w_ins;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] model_pc = 32'h0;
  logic [31:0] sb_pc [$];
  logic [31:0] pend_a [$];
  int          pend_d [$];

  ifetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_v(imem_req_v), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_v(imem_resp_v), .imem_resp_data(imem_resp_data),
    .redirect_v(redirect_v), .redirect_pc(redirect_pc), .decode_stall(decode_stall),
    .ifetch_decode_v(ifetch_decode_v), .ifetch_decode_pc(ifetch_decode_pc),
    .ifetch_decode_instruction(ifetch_decode_instruction)
  );

  ifetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_v(w_req_v), .imem_req_addr(w_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_v(imem_resp_v), .imem_resp_data(imem_resp_data),
    .redirect_v(redirect_v), .redirect_pc(redirect_pc), .decode_stall(decode_stall),
    .ifetch_decode_v(w_v), .ifetch_decode_pc(w_pc),
    .ifetch_decode_instruction(w_ins)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: responds in order, fixed latency, one per cycle
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      pend_a.delete();
      pend_d.delete();
      imem_resp_v    = 1'b0;
      imem_resp_data = 32'h0;
    end else if (pend_a.size() > 0 && pend_d[0] <= cyc) begin
      imem_resp_v    = 1'b1;
      imem_resp_data = mem_word(pend_a[0]);
      void'(pend_a.pop_front());
      void'(pend_d.pop_front());
    end else begin
      imem_resp_v    = 1'b0;
      imem_resp_data = 32'h0;
    end
  end

  // Scoreboard: push expected pc on each accepted request, pop on each valid output
  always @(negedge clk) begin
    if (!rst) begin
      sb_pc.delete();
      model_pc = 32'h0;
    end else begin
      if (ifetch_decode_v) begin
        n_checks++;
        if (sb_pc.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected_output: got pc %h, expected no valid output", ifetch_decode_pc);
        end else begin
          logic [31:0] e;
          e = sb_pc.pop_front();
          if (ifetch_decode_pc !== e || ifetch_decode_instruction !== mem_word(e)) begin
            n_errors++;
            $display("FAIL sb_output: got pc %h ins %h, expected pc %h ins %h",
                     ifetch_decode_pc, ifetch_decode_instruction, e, mem_word(e));
          end
        end
      end else begin
        n_checks++;
        if (ifetch_decode_instruction !== NOP) begin
          n_errors++;
          $display("FAIL sb_bubble_nop: got %h, expected %h", ifetch_decode_instruction, NOP);
        end
      end
      if (imem_req_v && imem_req_ready) begin
        n_checks++;
        if (imem_req_addr !== model_pc) begin
          n_errors++;
          $display("FAIL sb_req_addr: got %h, expected %h", imem_req_addr, model_pc);
        end
        pend_a.push_back(imem_req_addr);
        pend_d.push_back(cyc + lat);
        sb_pc.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
      if (redirect_v) begin
        sb_pc.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int l);
    lat = l; rst = 1'b0; imem_req_ready = 1'b1; decode_stall = 1'b0;
    redirect_v = 1'b0; redirect_pc = 32'h0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    lat = 1; rst = 1'b0; imem_req_ready = 1'b1; decode_stall = 1'b0;
    redirect_v = 1'b0; redirect_pc = 32'h0;
    repeat (2) tick();
    @(negedge clk);
    n_checks++;
    if (imem_req_v !== 1'b0 || imem_req_addr !== 32'h0 || ifetch_decode_v !== 1'b0 ||
        ifetch_decode_pc !== 32'h0 || ifetch_decode_instruction !== NOP) begin
      n_errors++;
      $display("FAIL reset_values: got req_v %b addr %h v %b pc %h ins %h, expected 0 0 0 0 %h",
               imem_req_v, imem_req_addr, ifetch_decode_v, ifetch_decode_pc,
               ifetch_decode_instruction, NOP);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req_v !== 1'b0) begin
      n_errors++; $display("FAIL reset_idle_cycle: got req_v %b, expected 0", imem_req_v);
    end
    tick(); @(negedge clk);
    n_checks++;
    if (imem_req_v !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_errors++; $display("FAIL reset_first_req: got v %b addr %h, expected 1 0", imem_req_v, imem_req_addr);
    end
    tick(); @(negedge clk);
    n_checks++;
    if (ifetch_decode_v !== 1'b0 || ifetch_decode_instruction !== NOP) begin
      n_errors++; $display("FAIL reset_cycle2_nop: got v %b ins %h, expected 0 %h",
                           ifetch_decode_v, ifetch_decode_instruction, NOP);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      n_checks++;
      if (ifetch_decode_v !== 1'b1 || ifetch_decode_pc !== 32'(4 * i)) begin
        n_errors++; $display("FAIL reset_stream: got v %b pc %h, expected 1 %h",
                             ifetch_decode_v, ifetch_decode_pc, 32'(4 * i));
      end
    end
    imem_req_ready = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (sb_pc.size() != 0) begin
      n_errors++; $display("FAIL reset_drain: got %0d pending, expected 0", sb_pc.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    repeat (3) tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req_v !== 1'b1 || imem_req_addr !== 32'h8) begin
        n_errors++; $display("FAIL bp_hold: got v %b addr %h, expected 1 00000008", imem_req_v, imem_req_addr);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    repeat (10) tick();
    imem_req_ready = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (sb_pc.size() != 0) begin
      n_errors++; $display("FAIL bp_drain: got %0d pending, expected 0", sb_pc.size());
    end
  endtask

  task automatic test_stall_credits();
    int acc = 0;
    do_reset(1);
    decode_stall = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req_v && imem_req_ready) acc++;
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (acc != 4 || imem_req_v !== 1'b0 || ifetch_decode_v !== 1'b0) begin
      n_errors++; $display("FAIL stall_credits: got acc %0d req_v %b v %b, expected 4 0 0",
                           acc, imem_req_v, ifetch_decode_v);
    end
    tick();
    decode_stall = 1'b0;
    tick(); @(negedge clk);
    n_checks++;
    if (ifetch_decode_v !== 1'b1 || ifetch_decode_pc !== 32'h0) begin
      n_errors++; $display("FAIL stall_release: got v %b pc %h, expected 1 0", ifetch_decode_v, ifetch_decode_pc);
    end
    repeat (8) tick();
    imem_req_ready = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (sb_pc.size() != 0) begin
      n_errors++; $display("FAIL stall_drain: got %0d pending, expected 0", sb_pc.size());
    end
  endtask

  task automatic test_redirect_inflight();
    bit found = 0;
    int when = 0;
    do_reset(3);
    repeat (4) tick();
    redirect_v = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    n_checks++;
    if (imem_req_v !== 1'b0) begin
      n_errors++; $display("FAIL redir_suppress: got req_v %b, expected 0", imem_req_v);
    end
    tick();
    redirect_v = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_v !== 1'b1 || imem_req_addr !== 32'h100 || ifetch_decode_v !== 1'b0 ||
        ifetch_decode_instruction !== NOP) begin
      n_errors++; $display("FAIL redir_next: got req_v %b addr %h v %b ins %h, expected 1 00000100 0 %h",
                           imem_req_v, imem_req_addr, ifetch_decode_v, ifetch_decode_instruction, NOP);
    end
    for (int i = 1; i <= 20 && !found; i++) begin
      tick(); @(negedge clk);
      if (ifetch_decode_v) begin found = 1; when = i; end
    end
    n_checks++;
    if (!found || ifetch_decode_pc !== 32'h100 || when != 4) begin
      n_errors++; $display("FAIL redir_first_valid: got found %0d pc %h after %0d, expected 1 00000100 after 4",
                           found, ifetch_decode_pc, when);
    end
    repeat (6) tick();
    imem_req_ready = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (sb_pc.size() != 0) begin
      n_errors++; $display("FAIL redir_drain: got %0d pending, expected 0", sb_pc.size());
    end
  endtask

  task automatic test_redirect_resp_stall();
    do_reset(1);
    repeat (6) tick();
    redirect_v = 1'b1; redirect_pc = 32'h0000_0200; decode_stall = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_resp_v !== 1'b1) begin
      n_errors++; $display("FAIL rrs_setup: got resp_v %b, expected 1", imem_resp_v);
    end
    tick();
    redirect_v = 1'b0; decode_stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifetch_decode_v !== 1'b0 || ifetch_decode_instruction !== NOP || imem_req_addr !== 32'h200) begin
      n_errors++; $display("FAIL rrs_nop: got v %b ins %h addr %h, expected 0 %h 00000200",
                           ifetch_decode_v, ifetch_decode_instruction, imem_req_addr, NOP);
    end
    repeat (2) tick();
    @(negedge clk);
    n_checks++;
    if (ifetch_decode_v !== 1'b1 || ifetch_decode_pc !== 32'h200) begin
      n_errors++; $display("FAIL rrs_target: got v %b pc %h, expected 1 00000200", ifetch_decode_v, ifetch_decode_pc);
    end
    imem_req_ready = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (sb_pc.size() != 0) begin
      n_errors++; $display("FAIL rrs_drain: got %0d pending, expected 0", sb_pc.size());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      n_checks++;
      if (w_req_v !== 1'b1 || w_req_addr !== exp_a[i]) begin
        n_errors++; $display("FAIL wrap_addr: got v %b addr %h, expected 1 %h", w_req_v, w_req_addr, exp_a[i]);
      end
    end
    tick();
    redirect_v = 1'b1; redirect_pc = 32'hFFFF_FFF4;
    tick();
    redirect_v = 1'b0;
    repeat (8) tick();
    imem_req_ready = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (sb_pc.size() != 0) begin
      n_errors++; $display("FAIL wrap_drain: got %0d pending, expected 0", sb_pc.size());
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_stall_credits();
    test_redirect_inflight();
    test_redirect_resp_stall();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end
endmodule
